// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, segment table and index-width helper for the 7-segment scanner
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to active-low segment decoder
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - multiplexed N-digit 7-segment scanner with activity LED; SEG7_LZB_EN enables leading-zero blanking
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int LED_HOLD    = 50000000
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    data_valid,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output seg_t                    seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    led
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int LED_W = $clog2(LED_HOLD + 1);

    logic [4*NUM_DIGITS-1:0] shadow;
    logic [PRE_W-1:0]        pre;
    logic [IDX_W-1:0]        idx;
    logic [LED_W-1:0]        led_cnt;

    logic [NUM_DIGITS-1:0]   lzb;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_lz;
    logic [NUM_DIGITS-1:0]   cur_an;
    seg_t                    dec_seg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow <= '0;
            pre    <= '0;
            idx    <= '0;
        end else begin
            if (data_valid) begin
                shadow <= data_in;
            end
            if (pre == PRE_W'(REFRESH_DIV - 1)) begin
                pre <= '0;
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

`ifdef SEG7_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        logic run;
        run = 1'b1;
        lzb = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run    = run && (shadow[4*i +: 4] == 4'h0);
            lzb[i] = run;
        end
    end
`else
    assign lzb = '0;
`endif

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        cur_an    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = shadow[4*i +: 4];
                cur_dp    = dp_mask[i];
                cur_blank = blank_mask[i];
                cur_lz    = lzb[i];
                cur_an[i] = 1'b0;
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // First cycle of each slot stays dark so the previous digit cannot ghost
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seg <= SEG_OFF;
            an  <= '1;
            dp  <= 1'b1;
        end else if (pre == '0 || cur_blank || (cur_lz && !cur_dp)) begin
            seg <= SEG_OFF;
            an  <= '1;
            dp  <= 1'b1;
        end else if (cur_lz) begin
            seg <= SEG_OFF;
            an  <= cur_an;
            dp  <= 1'b0;
        end else begin
            seg <= dec_seg;
            an  <= cur_an;
            dp  <= ~cur_dp;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_cnt <= '0;
            led     <= 1'b0;
        end else if (data_valid) begin
            led_cnt <= LED_W'(LED_HOLD);
            led     <= 1'b1;
        end else if (led_cnt != '0) begin
            led_cnt <= led_cnt - 1'b1;
            led     <= (led_cnt != LED_W'(1));
        end else begin
            led     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - directed self-checking bench for seg7_scan_display
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        data_valid = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        led;

    logic [11:0] data_in3 = 12'habc;
    logic [2:0]  dp_mask3 = 3'h0;
    logic [2:0]  blank_mask3 = 3'h0;
    logic [6:0]  seg3;
    logic [2:0]  an3;
    logic        dp3;
    logic        led3;

    int n_cmp = 0;
    int n_bad = 0;
    bit lzb_on;

    seg7_scan_display #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LED_HOLD(10)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .data_valid (data_valid),
        .data_in    (data_in),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .led        (led)
    );

    seg7_scan_display #(.NUM_DIGITS(3), .REFRESH_DIV(2), .LED_HOLD(10)) u_dut3 (
        .clk        (clk),
        .rstn       (rstn),
        .data_valid (data_valid),
        .data_in    (data_in3),
        .dp_mask    (dp_mask3),
        .blank_mask (blank_mask3),
        .seg        (seg3),
        .an         (an3),
        .dp         (dp3),
        .led        (led3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [15:0] d);
        rstn       = 1'b0;
        data_valid = 1'b0;
        tick;
        tick;
        rstn       = 1'b1;
        data_in    = d;
        dp_mask    = 4'h0;
        blank_mask = 4'h0;
    endtask

    initial begin
        int k, d, d3;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        logic [2:0] ea3;

`ifdef SEG7_LZB_EN
        lzb_on = 1'b1;
`else
        lzb_on = 1'b0;
`endif

        #1 rstn = 1'b0;
        #2;
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'hF);
        check("rst_dp", dp, 1'b1);
        check("rst_led", led, 1'b0);
        check("rst_an3", an3, 3'h7);

        // Scan with 16'h1234, masks applied from slot 5 on
        restart(16'h1234);
        data_valid = 1'b1;
        for (int s = 0; s < 9; s++) begin
            if (s == 5) begin
                dp_mask    = 4'b0100;
                blank_mask = 4'b0001;
            end
            for (int c = 0; c < 4; c++) begin
                tick;
                data_valid = 1'b0;
                k  = 4*s + c + 1;
                d  = s % 4;
                ea = 4'hF;
                es = 7'h7F;
                ed = 1'b1;
                if (c != 0 && !(s >= 5 && d == 0)) begin
                    ea[d] = 1'b0;
                    es    = hex7(data_in[4*d +: 4]);
                    ed    = (s >= 5 && d == 2) ? 1'b0 : 1'b1;
                end
                check("scan_an", an, ea);
                check("scan_seg", seg, es);
                check("scan_dp", dp, ed);
                check("scan_led", led, (k <= 10));
                ea3 = 3'h7;
                es  = 7'h7F;
                if (k % 2 == 0) begin
                    d3      = (k/2 - 1) % 3;
                    ea3[d3] = 1'b0;
                    es      = hex7(data_in3[4*d3 +: 4]);
                end
                check("np2_an", an3, ea3);
                check("np2_seg", seg3, es);
            end
        end
        dp_mask    = 4'h0;
        blank_mask = 4'h0;

        // Retrigger while high
        for (int j = 0; j < 18; j++) begin
            data_valid = (j == 0 || j == 5);
            tick;
            check("led_retrig", led, (j <= 14));
        end
        // Retrigger on the cycle the counter sits at 1
        for (int j = 0; j < 22; j++) begin
            data_valid = (j == 0 || j == 10);
            tick;
            check("led_at_one", led, (j <= 19));
        end
        data_valid = 1'b0;

        // Asynchronous reset in the middle of digit 2
        restart(16'h1234);
        data_valid = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick;
            data_valid = 1'b0;
        end
        check("mid_an", an, 4'b1011);
        check("mid_seg", seg, 7'h24);
        check("mid_led", led, 1'b1);
        rstn = 1'b0;
        #1;
        check("arst_seg", seg, 7'h7F);
        check("arst_an", an, 4'hF);
        check("arst_dp", dp, 1'b1);
        check("arst_led", led, 1'b0);
        tick;
        tick;
        rstn = 1'b1;
        tick;
        check("rel_blank_an", an, 4'hF);
        tick;
        check("rel_an", an, 4'b1110);
        check("rel_seg", seg, 7'h40);

        // Leading zeros: expectations depend on whether blanking is built in
        for (int t = 0; t < 2; t++) begin
            restart(t == 0 ? 16'h0050 : 16'h0000);
            data_valid = 1'b1;
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 4; c++) begin
                    tick;
                    data_valid = 1'b0;
                    if (c == 1) begin
                        ea = 4'hF;
                        es = 7'h7F;
                        if (!(lzb_on && s != 0 && (data_in >> (4*s)) == 16'h0)) begin
                            ea[s] = 1'b0;
                            es    = hex7(data_in[4*s +: 4]);
                        end
                        check("lzb_an", an, ea);
                        check("lzb_seg", seg, es);
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
Parametrised multiplexed 7-segment driver for the Basys3 display, generalising the 2-digit scancode viewer.
- Latches an N-digit hex word on a valid strobe into a shadow register.
- Scans the digits with a configurable refresh rate and per-digit decimal-point and blanking masks.
- Stretches each strobe into a retriggerable activity LED pulse.
- Sits between the PS/2 decoder (or any status source) and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal 1..8.
REFRESH_DIV, 100000, clk cycles each digit is driven; legal >= 2.
LED_HOLD, 50000000, clk cycles led stays high after the last strobe; legal >= 1.

Ports:
clk  in  1  system clock, 100 MHz.
rstn  in  1  asynchronous active-low reset.
data_valid  in  1  strobe; latch data_in this cycle.
data_in  in  4*NUM_DIGITS  hex nibbles; digit i = data_in[4i+3:4i], digit 0 rightmost.
dp_mask  in  NUM_DIGITS  1 = light the decimal point of digit i; sampled live, not latched.
blank_mask  in  NUM_DIGITS  1 = digit i dark; sampled live.
seg  out  7  segments {g,f,e,d,c,b,a}, active low.
an  out  NUM_DIGITS  digit anodes, active low, at most one low.
dp  out  1  decimal point, active low.
led  out  1  activity LED, active high.

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. While rstn is low, all state clears:
  - shadow=0, prescaler=0, digit index=0, LED counter=0.
  - Outputs: seg=7'h7F, an=all ones, dp=1, led=0.
- Shadow latch:
  - On a rising edge with data_valid=1, shadow<=data_in.
  - The new value is visible from the next refresh slot of each digit; no mid-slot glitch requirement beyond the output register.
- Prescaler: counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and the digit index advances.
  - Index advance is idx+1; NUM_DIGITS-1 wraps to 0. The index never exceeds NUM_DIGITS-1, including for non-power-of-2 digit counts.
- Outputs are registered, with 1-cycle latency from index/shadow/mask to pins.
  - an[idx]=0, all other anode bits 1.
  - seg = hex decode of the shadow nibble for idx.
  - dp = ~dp_mask[idx].
- Anti-ghosting: in the first cycle of every slot (prescaler==0), an=all ones and seg=7'h7F.
- Blanking: if blank_mask[idx]=1, then an=all ones, seg=7'h7F and dp=1 for the whole slot.
- LED stretcher:
  - data_valid=1 loads counter<=LED_HOLD and sets led<=1 on the next edge.
  - Otherwise, a nonzero counter decrements; led<=1 while the post-decrement value is nonzero.
  - Result: led is high for exactly LED_HOLD cycles after the last strobe.
  - A strobe while led is high reloads the counter (retrigger); no gap.
  - A strobe on the same cycle the counter reaches 1 also reloads; led stays high.
- Reset mid-operation: outputs go to reset values immediately (asynchronous); scanning restarts at digit 0 with a full first slot.

Optional Feature:
Macro SEG7_LZB_EN (leading-zero blanking).
- Defined:
  - A digit is blanked as if its blank_mask bit were set when it and every higher digit hold 0.
  - Digit 0 is never blanked by this rule; value 0 shows a single "0".
  - dp_mask still lights the dp of an LZB-blanked digit: anode low, seg=7'h7F.
- Undefined: all digits show their nibble; only blank_mask blanks.

Decomposition:
- Package seg7_pkg:
  - 16-entry constant hex-to-segment table: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, B=7'h03, C=7'h46, D=7'h21, E=7'h06, F=7'h0E.
  - SEG_OFF=7'h7F.
  - Index width function clog2(NUM_DIGITS), minimum 1.
- One sub-module, seg7_hex_decode: combinational 4-bit nibble to 7-bit active-low segments via the package table.

Test Plan:
- Reset/scan: NUM_DIGITS=4, REFRESH_DIV=4, data_in=16'h1234 strobed once.
  - an per slot, after the 1 blank cycle: 1110, 1101, 1011, 0111, then wraps.
  - seg per slot: 7'h19, 7'h30, 7'h24, 7'h79.
  - Each slot: 1 blank cycle + 3 driven cycles.
- Non-power-of-2: NUM_DIGITS=3, REFRESH_DIV=2.
  - Index sequence 0,1,2,0; an is never 3'b111 outside blank cycles and never has two lows.
- Masks: dp_mask=4'b0100, blank_mask=4'b0001.
  - Digit 0 slot: an=1111, seg=7'h7F, dp=1.
  - Digit 2 slot: dp=0.
  - Others: dp=1.
- LED: LED_HOLD=10, strobe at cycle 0 → led high cycles 1..10, low at 11.
  - Re-strobe at cycle 5 → led high through cycle 15 with no dip.
- Reset mid-slot: assert rstn=0 mid digit 2 → same-cycle seg=7'h7F, an=1111, led=0.
  - After release: digit 0 slot first; shadow reads 0 (seg=7'h40).
- SEG7_LZB_EN: data_in=16'h0050 → digits 3 and 2 dark, digit 1 = 7'h12, digit 0 = 7'h40.
  - data_in=16'h0000 → only digit 0 lit with "0".
